// File: rtl/axi_burst_master_if.sv
// AXI4 master-side bus bundle for axi_burst_master: AW, W, B, AR and R channels.
// The master modport faces the fabric; the slave modport is for responders and models.
interface axi_burst_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator: one local command becomes one burst,
// write data and read data stream straight through, done pulses with the merged response.
module axi_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done,
  output logic [1:0]            done_resp,
  axi_burst_master_if.master    m_axi
);

  localparam int                    SIZE       = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [1:0]            SLVERR     = 2'b10;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_AR   = 3'd4;
  localparam logic [2:0] S_R    = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic [1:0]            resp_q;
  logic                  len_err_q;

  logic cmd_fire;
  logic aw_fire;
  logic w_fire;
  logic b_fire;
  logic ar_fire;
  logic r_fire;
  logic last_beat;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign aw_fire   = (state == S_AW) & m_axi.awready;
  assign w_fire    = (state == S_W) & wr_valid & m_axi.wready;
  assign b_fire    = (state == S_B) & m_axi.bvalid;
  assign ar_fire   = (state == S_AR) & m_axi.arready;
  assign r_fire    = (state == S_R) & m_axi.rvalid & rd_ready;
  assign last_beat = (beat_cnt == len_q);

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cmd_fire) state_nxt = cmd_write ? S_AW : S_AR;
      S_AW:   if (aw_fire) state_nxt = S_W;
      S_W:    if (w_fire && last_beat) state_nxt = S_B;
      S_B:    if (b_fire) state_nxt = S_DONE;
      S_AR:   if (ar_fire) state_nxt = S_R;
      S_R:    if (r_fire && m_axi.rlast) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every register here uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      resp_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // Registered so it stays low through reset and rises on the first clock after it.
      cmd_ready <= (state_nxt == S_IDLE);

      if (cmd_fire) begin
        addr_q    <= cmd_addr & ALIGN_MASK;
        len_q     <= cmd_len;
        beat_cnt  <= '0;
        resp_q    <= '0;
        len_err_q <= 1'b0;
      end

      if (w_fire) beat_cnt <= last_beat ? '0 : beat_cnt + 8'd1;

      if (b_fire) resp_q <= m_axi.bresp;

      if (r_fire) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (m_axi.rresp > resp_q) resp_q <= m_axi.rresp;
        // Slave's burst length disagreeing with ours poisons the whole response.
        if (m_axi.rlast != last_beat) len_err_q <= 1'b1;
      end
    end
  end

  assign done      = (state == S_DONE);
  assign done_resp = !done ? 2'b00 : (len_err_q ? SLVERR : resp_q);

  assign m_axi.awid    = ID_WIDTH'(AXI_ID);
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = 3'(SIZE);
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = (state == S_AW);

  assign m_axi.wdata  = wr_data;
  assign m_axi.wstrb  = '1;
  assign m_axi.wlast  = (state == S_W) & last_beat;
  assign m_axi.wvalid = (state == S_W) & wr_valid;
  assign wr_ready     = (state == S_W) & m_axi.wready;

  assign m_axi.bready = (state == S_B);

  assign m_axi.arid    = ID_WIDTH'(AXI_ID);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arsize  = 3'(SIZE);
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'b0011;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = (state == S_AR);

  assign m_axi.rready = (state == S_R) & rd_ready;
  assign rd_valid     = (state == S_R) & m_axi.rvalid;
  assign rd_data      = m_axi.rdata;
  assign rd_last      = (state == S_R) & m_axi.rlast;

  // Response IDs are not checked: only one transaction is ever outstanding.
  logic unused_ids;
  assign unused_ids = ^{m_axi.bid, m_axi.rid};

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: acts as AXI slave, data producer and consumer with random
// stalls; a word-addressed reference memory predicts every beat and response.
module tb_axi_burst_master;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  len;
    int          stall;     // percent of cycles each side withholds valid/ready
    logic [31:0] base;      // write data is base, base+1, ...
    logic [1:0]  bresp;
    int          err_beat;  // read beat carrying err_resp, -1 for none
    logic [1:0]  err_resp;
    int          early;     // slave raises rlast on this beat, -1 for normal
    logic [1:0]  exp_resp;
  } cmd_vec_t;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready;
  logic        done;
  logic [1:0]  done_resp;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] slv_mem [int];

  axi_burst_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) axi ();

  axi_burst_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(8), .AXI_ID(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp),
    .m_axi(axi.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : (32'hA500_0000 | 32'(w));
  endfunction

  function automatic logic [31:0] slv_rd(input int w);
    return slv_mem.exists(w) ? slv_mem[w] : (32'hA500_0000 | 32'(w));
  endfunction

  function automatic bit go(input int stall);
    return ($urandom_range(0, 99) >= stall);
  endfunction

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 0; rd_ready = 0;
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bid = '0; axi.bresp = '0; axi.bvalid = 0;
    axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 0; axi.rvalid = 0;
  endtask

  // Issues one command and plays slave/producer/consumer until done; abort_beats >= 0
  // returns right after that many W beats so the caller can pull reset mid-burst.
  task automatic run_cmd(input cmd_vec_t v, input int abort_beats);
    logic [31:0] wq [256];
    logic [15:0] exp_addr, aw_prev, ar_prev;
    int base_w, nbeats, w_idx, r_idx, dut_w, dut_r, guard;
    bit aw_done, ar_done, b_done, fin, aw_wait, ar_wait, hs_w, hs_p, hs_r, hs_c, complete;

    exp_addr = v.addr & 16'hFFFC;
    base_w   = int'(v.addr >> 2);
    nbeats   = (!v.wr && v.early >= 0) ? v.early + 1 : int'(v.len) + 1;
    for (int i = 0; i < 256; i++) wq[i] = v.base + 32'(i);
    w_idx = 0; r_idx = 0; dut_w = 0; dut_r = 0; guard = 0;
    aw_done = 0; ar_done = 0; b_done = 0; fin = 0; aw_wait = 0; ar_wait = 0;
    aw_prev = '0; ar_prev = '0;

    while (cmd_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    check("cmd_ready before command", cmd_ready, 1);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
    @(negedge clk);
    cmd_valid = 0; cmd_addr = 16'($urandom); cmd_len = 8'($urandom);
    check("cmd_ready drops after accept", cmd_ready, 0);
    check("addr valid one cycle after cmd", {axi.awvalid, axi.arvalid}, v.wr ? 2'b10 : 2'b01);

    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      axi.awready = go(v.stall);
      axi.arready = go(v.stall);
      axi.wready  = go(v.stall);
      wr_valid    = go(v.stall);
      wr_data     = (w_idx <= int'(v.len)) ? wq[w_idx] : $urandom;
      rd_ready    = go(v.stall);
      axi.bresp   = v.bresp;
      axi.bvalid  = (v.wr && w_idx > int'(v.len) && !b_done) ? go(v.stall) : 1'b0;
      axi.rvalid  = (ar_done && r_idx < nbeats) ? go(v.stall) : 1'b0;
      axi.rdata   = slv_rd(dut_r + r_idx);
      axi.rresp   = (r_idx == v.err_beat) ? v.err_resp : 2'b00;
      axi.rlast   = (r_idx == nbeats - 1);
      #1;

      if (!done) check("done_resp zero outside done", done_resp, 0);
      if (v.wr) begin
        check("read side quiet during write", {axi.arvalid, axi.rready, rd_valid, rd_last}, 0);
        hs_w = axi.wvalid & axi.wready;
        hs_p = wr_valid & wr_ready;
        check("W beat matches stream beat", hs_w, hs_p);
        if (axi.awvalid) begin
          if (aw_wait) check("awaddr stable while stalled", axi.awaddr, aw_prev);
          aw_prev = axi.awaddr;
          aw_wait = !axi.awready;
          if (axi.awready) begin
            check("awaddr", axi.awaddr, exp_addr);
            check("awlen", axi.awlen, v.len);
            check("aw constants id/size/burst/lock/cache/prot",
                  {axi.awid, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot},
                  {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
            dut_w = int'(axi.awaddr >> 2);
            aw_done = 1;
          end
        end
        if (hs_w) begin
          check("W after AW", aw_done, 1);
          if (w_idx <= int'(v.len)) begin
            check("wdata", axi.wdata, wq[w_idx]);
            check("wlast", axi.wlast, (w_idx == int'(v.len)));
            check("wstrb", axi.wstrb, 4'hF);
            slv_mem[dut_w + w_idx]  = axi.wdata;
            ref_mem[base_w + w_idx] = wq[w_idx];
          end else begin
            check("extra W beat index", w_idx, int'(v.len));
          end
          w_idx++;
        end
        if (axi.bvalid && axi.bready) b_done = 1;
      end else begin
        check("write side quiet during read",
              {axi.awvalid, axi.wvalid, axi.wlast, wr_ready, axi.bready}, 0);
        hs_r = axi.rvalid & axi.rready;
        hs_c = rd_valid & rd_ready;
        check("R beat matches stream beat", hs_r, hs_c);
        if (axi.arvalid) begin
          if (ar_wait) check("araddr stable while stalled", axi.araddr, ar_prev);
          ar_prev = axi.araddr;
          ar_wait = !axi.arready;
          if (axi.arready) begin
            check("araddr", axi.araddr, exp_addr);
            check("arlen", axi.arlen, v.len);
            check("ar constants id/size/burst/lock/cache/prot",
                  {axi.arid, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot},
                  {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
            dut_r = int'(axi.araddr >> 2);
            ar_done = 1;
          end
        end
        if (hs_c) begin
          check("rd_data", rd_data, ref_rd(base_w + r_idx));
          check("rd_last", rd_last, (r_idx == nbeats - 1));
          r_idx++;
        end
      end

      if (done) begin
        complete = v.wr ? (b_done && w_idx == int'(v.len) + 1) : (r_idx == nbeats);
        check("done only after burst completes", complete, 1);
        check("done_resp", done_resp, v.exp_resp);
        fin = 1;
      end
      if (abort_beats >= 0 && w_idx >= abort_beats) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end

    check("command finished within budget", fin, 1);
    idle_inputs();
    #1;
    check("done is a single-cycle pulse", done, 0);
    check("cmd_ready back after done", cmd_ready, 1);
  endtask

  cmd_vec_t vecs [12];
  cmd_vec_t rv;

  initial begin
    vecs[0]  = '{1'b1, 16'h0100, 8'd3,   0,  32'd1,      2'b00, -1, 2'b00, -1, 2'b00};
    vecs[1]  = '{1'b0, 16'h0100, 8'd3,   0,  32'd0,      2'b00, -1, 2'b00, -1, 2'b00};
    vecs[2]  = '{1'b1, 16'h0103, 8'd0,   0,  32'h55,     2'b00, -1, 2'b00, -1, 2'b00};
    vecs[3]  = '{1'b0, 16'h0101, 8'd1,   0,  32'd0,      2'b00, -1, 2'b00, -1, 2'b00};
    vecs[4]  = '{1'b1, 16'h0200, 8'd7,   50, 32'h1000,   2'b00, -1, 2'b00, -1, 2'b00};
    vecs[5]  = '{1'b0, 16'h0200, 8'd7,   50, 32'd0,      2'b00, -1, 2'b00, -1, 2'b00};
    vecs[6]  = '{1'b1, 16'h0300, 8'd3,   0,  32'h2000,   2'b10, -1, 2'b00, -1, 2'b10};
    vecs[7]  = '{1'b0, 16'h0200, 8'd3,   0,  32'd0,      2'b00,  1, 2'b10, -1, 2'b10};
    vecs[8]  = '{1'b0, 16'h0200, 8'd3,   0,  32'd0,      2'b00, -1, 2'b00,  1, 2'b10};
    vecs[9]  = '{1'b0, 16'h0200, 8'd3,   50, 32'd0,      2'b00,  0, 2'b01, -1, 2'b01};
    vecs[10] = '{1'b1, 16'h0400, 8'd255, 0,  32'h3000,   2'b00, -1, 2'b00, -1, 2'b00};
    vecs[11] = '{1'b0, 16'h0400, 8'd255, 20, 32'd0,      2'b00, -1, 2'b00, -1, 2'b00};

    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("reset: cmd_ready low", cmd_ready, 0);
    check("reset: valids/ready/done low",
          {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, rd_valid, wr_ready, done}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready after reset", cmd_ready, 1);

    foreach (vecs[i]) run_cmd(vecs[i], -1);

    for (int i = 0; i < 24; i++) begin
      rv.wr       = 1'($urandom_range(0, 1));
      rv.addr     = 16'h1000 + 16'($urandom_range(0, 63) * 4) + 16'($urandom_range(0, 3));
      rv.len      = 8'($urandom_range(0, 15));
      rv.stall    = 50;
      rv.base     = $urandom;
      rv.bresp    = 2'b00;
      rv.err_beat = -1;
      rv.err_resp = 2'b00;
      rv.early    = -1;
      rv.exp_resp = 2'b00;
      run_cmd(rv, -1);
    end

    // Reset in the middle of a write burst: everything drops at once, then a fresh command works.
    rv = '{1'b1, 16'h0600, 8'd7, 0, 32'h4000, 2'b00, -1, 2'b00, -1, 2'b00};
    run_cmd(rv, 3);
    wr_valid = 1; axi.wready = 1; axi.awready = 1; axi.arready = 1; axi.rvalid = 1; rd_ready = 1;
    rst_n = 1'b0;
    #1;
    check("mid-burst reset: outputs low",
          {cmd_ready, axi.awvalid, axi.wvalid, axi.wlast, wr_ready, axi.bready,
           axi.arvalid, axi.rready, rd_valid, rd_last, done, done_resp}, 0);
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready after mid-burst reset", cmd_ready, 1);
    rv = '{1'b1, 16'h0700, 8'd3, 0, 32'h5000, 2'b00, -1, 2'b00, -1, 2'b00};
    run_cmd(rv, -1);
    rv = '{1'b0, 16'h0700, 8'd3, 30, 32'd0, 2'b00, -1, 2'b00, -1, 2'b00};
    run_cmd(rv, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
